// File: rtl/motor_reg_arbiter.sv
// Two-requester round-robin arbiter that turns register reads/writes into AXI4-Lite transactions.
// Optional watchdog: define MOTOR_ARB_TIMEOUT_EN to abort stalled transactions after TIMEOUT cycles.
module motor_reg_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [3:0]  idx_i,
    input  logic [63:0] wdata_i,
    output logic [1:0]  done_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  resp_o,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

    state_t      state;
    logic        grant;
    logic        prio;
    logic [1:0]  idx_r;
    logic [31:0] wdata_r;
    logic        req_sel;
    logic        tmo_abort;
    logic [31:0] reg_addr;

    // prio names the requester that wins when both are asking
    assign req_sel  = (req_i == 2'b11) ? prio : ~req_i[0];
    assign reg_addr = BASE_ADDR + {28'd0, idx_r, 2'b00};

    assign M_AXI_AWADDR = reg_addr;
    assign M_AXI_ARADDR = reg_addr;
    assign M_AXI_WDATA  = wdata_r;

`ifdef MOTOR_ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        busy;
    logic        finishing;

    assign busy      = (state == WADDR) || (state == WRESP) ||
                       (state == RADDR) || (state == RDATA);
    assign finishing = ((state == WRESP) && M_AXI_BVALID) ||
                       ((state == RDATA) && M_AXI_RVALID);
    assign tmo_abort = busy && !finishing && (tmo_cnt == TIMEOUT - 1);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if (busy) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end
`else
    assign tmo_abort = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            grant         <= 1'b0;
            prio          <= 1'b0;
            idx_r         <= '0;
            wdata_r       <= '0;
            done_o        <= '0;
            rdata_o       <= '0;
            resp_o        <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            done_o <= 2'b00;
            if (tmo_abort) begin
                M_AXI_AWVALID <= 1'b0;
                M_AXI_WVALID  <= 1'b0;
                M_AXI_BREADY  <= 1'b0;
                M_AXI_ARVALID <= 1'b0;
                M_AXI_RREADY  <= 1'b0;
                resp_o        <= 2'b10;
                done_o        <= {grant, ~grant};
                state         <= DONE;
            end else begin
                case (state)
                    IDLE: begin
                        if (|req_i) begin
                            grant   <= req_sel;
                            prio    <= ~req_sel;
                            idx_r   <= req_sel ? idx_i[3:2] : idx_i[1:0];
                            wdata_r <= req_sel ? wdata_i[63:32] : wdata_i[31:0];
                            if (we_i[req_sel]) begin
                                M_AXI_AWVALID <= 1'b1;
                                M_AXI_WVALID  <= 1'b1;
                                state         <= WADDR;
                            end else begin
                                M_AXI_ARVALID <= 1'b1;
                                state         <= RADDR;
                            end
                        end
                    end
                    WADDR: begin
                        // a channel whose valid is already low has completed its handshake
                        if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                        if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                        if ((!M_AXI_AWVALID || M_AXI_AWREADY) &&
                            (!M_AXI_WVALID  || M_AXI_WREADY)) begin
                            M_AXI_BREADY <= 1'b1;
                            state        <= WRESP;
                        end
                    end
                    WRESP: begin
                        if (M_AXI_BVALID) begin
                            resp_o       <= M_AXI_BRESP;
                            M_AXI_BREADY <= 1'b0;
                            done_o       <= {grant, ~grant};
                            state        <= DONE;
                        end
                    end
                    RADDR: begin
                        if (M_AXI_ARREADY) begin
                            M_AXI_ARVALID <= 1'b0;
                            M_AXI_RREADY  <= 1'b1;
                            state         <= RDATA;
                        end
                    end
                    RDATA: begin
                        if (M_AXI_RVALID) begin
                            rdata_o      <= M_AXI_RDATA;
                            resp_o       <= M_AXI_RRESP;
                            M_AXI_RREADY <= 1'b0;
                            done_o       <= {grant, ~grant};
                            state        <= DONE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motor_reg_arbiter.sv
// Randomized self-checking bench for motor_reg_arbiter with a behavioural AXI-Lite slave.
// Build with MOTOR_ARB_TIMEOUT_EN defined to include the watchdog scenario.
module tb_motor_reg_arbiter;

    localparam logic [31:0] BASE = 32'hFFFF_FFF4;
    localparam int          TMO  = 16;

    logic        tb_ACLK = 1'b0;
    logic        ARESETN;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [3:0]  idx_i;
    logic [63:0] wdata_i;
    logic [1:0]  done_o;
    logic [31:0] rdata_o;
    logic [1:0]  resp_o;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [4];
    logic [31:0] slave_mem [4];
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          last_grant;
    bit          pend  [2];
    bit          r_we  [2];
    logic [1:0]  r_idx [2];
    logic [31:0] r_data[2];

    always #5 tb_ACLK = ~tb_ACLK;

    motor_reg_arbiter #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .ACLK(tb_ACLK), .ARESETN(ARESETN),
        .req_i(req_i), .we_i(we_i), .idx_i(idx_i), .wdata_i(wdata_i),
        .done_o(done_o), .rdata_o(rdata_o), .resp_o(resp_o),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
        .M_AXI_RREADY(RREADY)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int r, input bit we, input logic [1:0] idx, input logic [31:0] data);
        pend[r]   = 1'b1;
        r_we[r]   = we;
        r_idx[r]  = idx;
        r_data[r] = data;
        req_i[r]  = 1'b1;
        we_i[r]   = we;
        idx_i[r*2 +: 2]    = idx;
        wdata_i[r*32 +: 32] = data;
    endtask

    function automatic logic [31:0] regAddr(input logic [1:0] idx);
        return BASE + 32'(idx) * 32'd4;
    endfunction

    function automatic logic [1:0] randResp();
        int k;
        k = $urandom_range(0, 3);
        if (k == 2) return 2'b10;
        if (k == 3) return 2'b11;
        return 2'b00;
    endfunction

    // Plays the slave for one granted transaction and checks it against the model.
    task automatic serveGrant(input int aw_dly, input int w_dly, input int b_dly,
                              input int ar_dly, input int r_dly, input logic [1:0] sresp);
        int          g;
        int          c;
        bit          seen, aw_hs, w_hs, ar_hs;
        logic [31:0] cap_addr, cap_data;
        logic [1:0]  sidx;
        if (pend[0] && pend[1]) g = (last_grant == 0) ? 1 : 0;
        else                    g = pend[1] ? 1 : 0;
        seen = 1'b0;
        for (c = 0; c < 10 && !seen; c++) begin
            if (AWVALID || ARVALID) seen = 1'b1;
            else @(negedge tb_ACLK);
        end
        if (!seen) begin
            checkOutput("grant_wait", 64'd0, 64'd1);
            return;
        end
        cap_addr = '0;
        cap_data = '0;
        checkOutput("txn_is_write", 64'(AWVALID), 64'(r_we[g]));
        if (AWVALID) begin
            checkOutput("awaddr", 64'(AWADDR), 64'(regAddr(r_idx[g])));
            checkOutput("wdata", 64'(WDATA), 64'(r_data[g]));
            aw_hs = 1'b0;
            w_hs  = 1'b0;
            c     = 0;
            while (!(aw_hs && w_hs) && c < 40) begin
                checkOutput("awvalid_level", 64'(AWVALID), 64'(!aw_hs));
                checkOutput("wvalid_level", 64'(WVALID), 64'(!w_hs));
                AWREADY = (c >= aw_dly);
                WREADY  = (c >= w_dly);
                if (AWVALID && AWREADY) begin aw_hs = 1'b1; cap_addr = AWADDR; end
                if (WVALID && WREADY)   begin w_hs  = 1'b1; cap_data = WDATA;  end
                @(negedge tb_ACLK);
                c++;
            end
            AWREADY = 1'b0;
            WREADY  = 1'b0;
            checkOutput("aw_w_dropped", 64'({AWVALID, WVALID}), 64'd0);
            for (int k = 0; k <= b_dly; k++) begin
                checkOutput("bready", 64'(BREADY), 64'd1);
                BVALID = (k == b_dly);
                BRESP  = sresp;
                @(negedge tb_ACLK);
            end
            BVALID = 1'b0;
            BRESP  = 2'b00;
            sidx = 2'((cap_addr - BASE) >> 2);
            slave_mem[sidx]     = cap_data;
            model_mem[r_idx[g]] = r_data[g];
            exp_resp = sresp;
        end else begin
            checkOutput("araddr", 64'(ARADDR), 64'(regAddr(r_idx[g])));
            ar_hs = 1'b0;
            c     = 0;
            while (!ar_hs && c < 40) begin
                checkOutput("arvalid_level", 64'(ARVALID), 64'd1);
                ARREADY = (c >= ar_dly);
                if (ARVALID && ARREADY) begin ar_hs = 1'b1; cap_addr = ARADDR; end
                @(negedge tb_ACLK);
                c++;
            end
            ARREADY = 1'b0;
            checkOutput("arvalid_dropped", 64'(ARVALID), 64'd0);
            sidx = 2'((cap_addr - BASE) >> 2);
            for (int k = 0; k <= r_dly; k++) begin
                checkOutput("rready", 64'(RREADY), 64'd1);
                RVALID = (k == r_dly);
                RDATA  = slave_mem[sidx];
                RRESP  = sresp;
                @(negedge tb_ACLK);
            end
            RVALID = 1'b0;
            RDATA  = $urandom;
            RRESP  = 2'b00;
            exp_rdata = model_mem[r_idx[g]];
            exp_resp  = sresp;
        end
        checkOutput("done_pulse", 64'(done_o), 64'({g == 1, g == 0}));
        checkOutput("rdata", 64'(rdata_o), 64'(exp_rdata));
        checkOutput("resp", 64'(resp_o), 64'(exp_resp));
        last_grant = g;
        pend[g]    = 1'b0;
        req_i[g]   = 1'b0;
        @(negedge tb_ACLK);
        checkOutput("done_single", 64'(done_o), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        int          n;
        int          cnt;
        int          c;
        bit          seen;
        ARESETN = 1'b0;
        req_i = '0; we_i = '0; idx_i = '0; wdata_i = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = '0;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0;
        for (int i = 0; i < 4; i++) begin
            model_mem[i] = 32'h5A00_0000 | 32'(i);
            slave_mem[i] = 32'h5A00_0000 | 32'(i);
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        exp_rdata  = '0;
        exp_resp   = '0;
        last_grant = -1;

        #1;
        checkOutput("reset_outputs", {rdata_o, resp_o, done_o}, 64'd0);
        checkOutput("reset_handshakes", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 64'd0);
        repeat (3) @(negedge tb_ACLK);
        ARESETN = 1'b1;

        $display("[TB] simultaneous requests after reset, req1 wraps the address");
        applyStimulus(0, 1'b1, 2'd0, 32'h0101_FFFF);
        applyStimulus(1, 1'b1, 2'd3, 32'hBEEF_0011);
        serveGrant(0, 0, 0, 0, 0, 2'b00);
        serveGrant(1, 1, 1, 0, 0, 2'b00);

        $display("[TB] read back");
        applyStimulus(0, 1'b0, 2'd0, 32'h0);
        serveGrant(0, 0, 0, 1, 2, 2'b00);
        applyStimulus(1, 1'b0, 2'd3, 32'h0);
        serveGrant(0, 0, 0, 0, 0, 2'b00);

        $display("[TB] independent write channel handshakes");
        applyStimulus(0, 1'b1, 2'd1, 32'h1111_2222);
        serveGrant(0, 3, 0, 0, 0, 2'b00);
        applyStimulus(0, 1'b1, 2'd2, 32'h3333_4444);
        serveGrant(3, 0, 2, 0, 0, 2'b00);
        applyStimulus(1, 1'b1, 2'd1, 32'h5555_6666);
        serveGrant(2, 2, 0, 0, 0, 2'b00);

        $display("[TB] error response on write keeps read data");
        applyStimulus(1, 1'b1, 2'd2, 32'hDEAD_0001);
        serveGrant(0, 0, 1, 0, 0, 2'b10);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 24; it++) begin
            n   = $urandom_range(1, 3);
            cnt = 0;
            for (int r = 0; r < 2; r++) begin
                if (((n >> r) & 1) == 1) begin
                    applyStimulus(r, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
                    cnt++;
                end
            end
            repeat (cnt) serveGrant($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                                    $urandom_range(0, 3), $urandom_range(0, 3), randResp());
        end

        $display("[TB] reset during read data wait");
        applyStimulus(1, 1'b0, 2'd1, 32'h0);
        seen = 1'b0;
        for (c = 0; c < 10 && !seen; c++) begin
            if (ARVALID) seen = 1'b1;
            else @(negedge tb_ACLK);
        end
        checkOutput("reset_txn_started", 64'(seen), 64'd1);
        ARREADY = 1'b1;
        @(negedge tb_ACLK);
        ARREADY = 1'b0;
        checkOutput("rready_before_reset", 64'(RREADY), 64'd1);
        ARESETN = 1'b0;
        #1;
        checkOutput("abort_outputs", {rdata_o, resp_o, done_o}, 64'd0);
        checkOutput("abort_handshakes", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 64'd0);
        pend[1]  = 1'b0;
        req_i    = '0;
        exp_rdata  = '0;
        exp_resp   = '0;
        last_grant = -1;
        repeat (3) begin
            @(negedge tb_ACLK);
            checkOutput("abort_no_done", 64'(done_o), 64'd0);
        end
        ARESETN = 1'b1;
        applyStimulus(0, 1'b0, 2'd1, 32'h0);
        serveGrant(0, 0, 0, 0, 1, 2'b00);
        applyStimulus(0, 1'b0, 2'd2, 32'h0);
        applyStimulus(1, 1'b0, 2'd3, 32'h0);
        serveGrant(0, 0, 0, 0, 0, 2'b11);
        serveGrant(0, 0, 0, 1, 0, 2'b00);

`ifdef MOTOR_ARB_TIMEOUT_EN
        $display("[TB] watchdog on a slave that never accepts the read address");
        applyStimulus(0, 1'b0, 2'd2, 32'h0);
        seen = 1'b0;
        for (c = 0; c < 10 && !seen; c++) begin
            if (ARVALID) seen = 1'b1;
            else @(negedge tb_ACLK);
        end
        checkOutput("tmo_txn_started", 64'(seen), 64'd1);
        c = 0;
        while (ARVALID && c < 40) begin
            @(negedge tb_ACLK);
            c++;
        end
        checkOutput("tmo_cycles", 64'(c), 64'(TMO));
        checkOutput("tmo_done", 64'(done_o), 64'd1);
        checkOutput("tmo_resp", 64'(resp_o), 64'd2);
        pend[0]  = 1'b0;
        req_i[0] = 1'b0;
        @(negedge tb_ACLK);
        checkOutput("tmo_done_single", 64'(done_o), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
